// File: rtl/fp_pkg.sv
// Shared flag layout and special-value encodings for the packed FP result path.
// Pure definitions: no state, no latency, no flow control.
package fp_pkg;

    localparam int FLAG_INVALID   = 3;
    localparam int FLAG_OVERFLOW  = 2;
    localparam int FLAG_UNDERFLOW = 1;
    localparam int FLAG_INEXACT   = 0;

    typedef logic [3:0] flags_t;

    // Words come back right-aligned in 128 bits; callers cast down to 1+exp_w+man_w.
    function automatic logic [127:0] inf_word(input int exp_w, input int man_w);
        logic [127:0] ones;
        ones = (128'd1 << exp_w) - 128'd1;
        return ones << man_w;
    endfunction

    function automatic logic [127:0] qnan_word(input int exp_w, input int man_w);
        return inf_word(exp_w, man_w) | (128'd1 << (man_w - 1));
    endfunction

endpackage

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even on {hidden, fraction, G, R, S} with carry renormalisation.
// Purely combinational; no backpressure.
module fp_round_rne
    import fp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic [MAN_W+3:0] sig,
    input  logic [EXP_W+1:0] exponent,
    output logic [MAN_W-1:0] frac,
    output logic [EXP_W+1:0] exp_rnd,
    output logic             inexact
);

    logic             lsb;
    logic             g;
    logic             rs;
    logic             round_up;
    logic [MAN_W+1:0] m;

    assign lsb      = sig[3];
    assign g        = sig[2];
    assign rs       = sig[1] | sig[0];
    assign round_up = g & (rs | lsb);
    assign inexact  = g | sig[1] | sig[0];

    assign m = {1'b0, sig[MAN_W+3:3]} + {{(MAN_W+1){1'b0}}, round_up};

    // A carry out means the significand became 10.000..., so the fraction is all zeros after the shift.
    always_comb begin
        frac    = m[MAN_W-1:0];
        exp_rnd = exponent;
        if (m[MAN_W+1]) begin
            frac    = m[MAN_W:1];
            exp_rnd = exponent + {{(EXP_W+1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/fp_result_packer.sv
// Rounds, classifies and packs a normalised result into an IEEE-style word; 2-cycle latency.
// Valid/ready: an output stall freezes both stages and drops in_ready in the same cycle.
module fp_result_packer
    import fp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_sign,
    input  logic [EXP_W+1:0]       in_exponent,
    input  logic [MAN_W+3:0]       in_significand,
    input  logic                   in_is_nan,
    input  logic                   in_is_inf,
    input  logic                   clear_flags,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   fp_out,
    output logic [3:0]             out_flags,
    output logic [3:0]             sticky_flags
);

    localparam int W = 1 + EXP_W + MAN_W;
    localparam logic [W-1:0]       QNAN    = W'(qnan_word(EXP_W, MAN_W));
    localparam logic [W-1:0]       INF_MAG = W'(inf_word(EXP_W, MAN_W));
    localparam logic [EXP_W+1:0]   EXP_MAX = {2'b00, {EXP_W{1'b1}}};

    typedef struct packed {
        logic             sign;
        logic [EXP_W+1:0] exp;
        logic [MAN_W-1:0] frac;
        logic             inexact;
        logic             nan;
        logic             inf;
        logic             zero;
    } s1_t;

    logic             stall;
    logic             s1_vld;
    s1_t              s1_d;
    s1_t              s1_q;
    logic [MAN_W-1:0] rnd_frac;
    logic [EXP_W+1:0] rnd_exp;
    logic             rnd_inexact;
    logic [W-1:0]     pack_dat;
    flags_t           pack_flags;
    logic             exp_ovf;
    logic             exp_unf;

    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;

    fp_round_rne #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W)
    ) u_round (
        .sig      (in_significand),
        .exponent (in_exponent),
        .frac     (rnd_frac),
        .exp_rnd  (rnd_exp),
        .inexact  (rnd_inexact)
    );

    always_comb begin
        s1_d         = '0;
        s1_d.sign    = in_sign;
        s1_d.exp     = rnd_exp;
        s1_d.frac    = rnd_frac;
        s1_d.inexact = rnd_inexact;
        s1_d.nan     = in_is_nan;
        s1_d.inf     = in_is_inf;
        s1_d.zero    = (in_significand == '0);
    end

    // Exponent is two's complement: the top bit marks a negative (deep underflow) value.
    assign exp_ovf = ~s1_q.exp[EXP_W+1] & (s1_q.exp >= EXP_MAX);
    assign exp_unf = s1_q.exp[EXP_W+1] | (s1_q.exp == '0);

    always_comb begin
        pack_dat   = '0;
        pack_flags = '0;
        if (s1_q.nan) begin
            pack_dat                 = QNAN;
            pack_flags[FLAG_INVALID] = 1'b1;
        end else if (s1_q.inf) begin
            pack_dat = {s1_q.sign, {(W-1){1'b0}}} | INF_MAG;
        end else if (s1_q.zero) begin
            pack_dat = {s1_q.sign, {(W-1){1'b0}}};
        end else if (exp_ovf) begin
            pack_dat                  = {s1_q.sign, {(W-1){1'b0}}} | INF_MAG;
            pack_flags[FLAG_OVERFLOW] = 1'b1;
            pack_flags[FLAG_INEXACT]  = 1'b1;
        end else if (exp_unf) begin
            pack_dat                   = {s1_q.sign, {(W-1){1'b0}}};
            pack_flags[FLAG_UNDERFLOW] = 1'b1;
            pack_flags[FLAG_INEXACT]   = 1'b1;
        end else begin
            pack_dat                 = {s1_q.sign, s1_q.exp[EXP_W-1:0], s1_q.frac};
            pack_flags[FLAG_INEXACT] = s1_q.inexact;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            s1_vld       <= 1'b0;
            s1_q         <= '0;
            out_valid    <= 1'b0;
            fp_out       <= '0;
            out_flags    <= '0;
            sticky_flags <= '0;
        end else begin
            if (!stall) begin
                s1_vld    <= in_valid;
                out_valid <= s1_vld;
                if (in_valid) begin
                    s1_q <= s1_d;
                end
                if (s1_vld) begin
                    fp_out    <= pack_dat;
                    out_flags <= pack_flags;
                end
            end
            // Flags of a result leaving this cycle survive a simultaneous clear.
            if (out_valid && out_ready) begin
                sticky_flags <= (clear_flags ? 4'b0000 : sticky_flags) | out_flags;
            end else if (clear_flags) begin
                sticky_flags <= 4'b0000;
            end
        end
    end

endmodule

// File: tb/tb_fp_result_packer.sv
// Scoreboard bench for fp_result_packer: directed plan vectors plus randomized traffic
// against an arithmetic reference model, with random backpressure and a mid-stream reset.
module tb_fp_result_packer;

    localparam int EXP_W = 8;
    localparam int MAN_W = 23;

    typedef struct packed {
        logic [3:0]  flags;
        logic [31:0] word;
    } exp_t;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_sign = 1'b0;
    logic [9:0]  in_exponent = '0;
    logic [26:0] in_significand = '0;
    logic        in_is_nan = 1'b0;
    logic        in_is_inf = 1'b0;
    logic        clear_flags = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] fp_out;
    logic [3:0]  out_flags;
    logic [3:0]  sticky_flags;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    logic [3:0]  sticky_model = '0;
    bit          rst_seen = 1'b0;
    bit          rand_done = 1'b0;

    always #5 clock = ~clock;

    fp_result_packer #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W)
    ) dut (
        .clock          (clock),
        .resetn         (resetn),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_sign        (in_sign),
        .in_exponent    (in_exponent),
        .in_significand (in_significand),
        .in_is_nan      (in_is_nan),
        .in_is_inf      (in_is_inf),
        .clear_flags    (clear_flags),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .fp_out         (fp_out),
        .out_flags      (out_flags),
        .sticky_flags   (sticky_flags)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: value-level rounding on the integer significand, then IEEE classification.
    function automatic exp_t model(input bit s, input int e, input logic [26:0] sig,
                                   input bit nan, input bit inf);
        exp_t   r;
        longint m;
        int     rem;
        int     ee;
        bit     inx;
        m   = longint'(sig >> 3);
        rem = int'(sig[2:0]);
        inx = (rem != 0);
        if (rem > 4 || (rem == 4 && (m % 2) == 1)) m = m + 1;
        ee = e;
        if (m >= (longint'(1) << 24)) begin
            m  = m / 2;
            ee = ee + 1;
        end
        r.flags = 4'b0000;
        if (nan) begin
            r.word  = 32'h7FC0_0000;
            r.flags = 4'b1000;
        end else if (inf) begin
            r.word = {s, 8'hFF, 23'h0};
        end else if (sig == 27'd0) begin
            r.word = {s, 31'h0};
        end else if (ee >= 255) begin
            r.word  = {s, 8'hFF, 23'h0};
            r.flags = 4'b0101;
        end else if (ee <= 0) begin
            r.word  = {s, 31'h0};
            r.flags = 4'b0011;
        end else begin
            r.word  = {s, 8'(ee), 23'(m)};
            r.flags = {3'b000, inx};
        end
        return r;
    endfunction

    // Called half a cycle... at posedge+1; returns at posedge+1 after the transfer edge.
    task automatic send(input bit s, input int e, input logic [26:0] sig,
                        input bit nan, input bit inf, input exp_t ex);
        bit accepted;
        accepted       = 1'b0;
        in_valid       = 1'b1;
        in_sign        = s;
        in_exponent    = 10'(e);
        in_significand = sig;
        in_is_nan      = nan;
        in_is_inf      = inf;
        for (int k = 0; k < 200; k++) begin
            @(negedge clock);
            if (in_ready) begin
                sb.push_back(ex);
                accepted = 1'b1;
                break;
            end
        end
        if (!accepted) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready stayed 0, expected 1");
        end
        @(posedge clock);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_m(input bit s, input int e, input logic [26:0] sig,
                          input bit nan, input bit inf);
        send(s, e, sig, nan, inf, model(s, e, sig, nan, inf));
    endtask

    task automatic drain();
        for (int k = 0; k < 200; k++) begin
            @(negedge clock);
            if (sb.size() == 0 && !out_valid) break;
        end
        check("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    task automatic rand_one();
        int          cat;
        bit          s;
        int          e;
        logic [26:0] sig;
        bit          nan;
        bit          inf;
        cat = int'($urandom_range(0, 19));
        s   = 1'($urandom_range(0, 1));
        sig = {1'b1, 26'($urandom())};
        e   = int'($urandom_range(1, 254));
        nan = 1'b0;
        inf = 1'b0;
        case (cat)
            0: nan = 1'b1;
            1: inf = 1'b1;
            2: sig = 27'd0;
            3: sig[26] = 1'b0;
            4, 5: e = int'($urandom_range(0, 6)) - 3;
            6, 7: e = 252 + int'($urandom_range(0, 6));
            8: sig[2:0] = 3'b100;
            9: sig[25:2] = 24'hFFFFFF;
            default: ;
        endcase
        send_m(s, e, sig, nan, inf);
    endtask

    // Monitor: pops the scoreboard on every presented result, tracks the sticky flags.
    always @(negedge clock) begin
        if (!resetn) begin
            sb.delete();
            sticky_model = '0;
            rst_seen     = 1'b1;
        end else begin
            if (rst_seen) begin
                check("reset_out_valid", 64'(out_valid), 64'd0);
                check("reset_fp_out", 64'(fp_out), 64'd0);
                check("reset_out_flags", 64'(out_flags), 64'd0);
                check("reset_in_ready", 64'(in_ready), 64'd1);
                rst_seen = 1'b0;
            end
            check("sticky_flags", 64'(sticky_flags), 64'(sticky_model));
            if (out_valid && !out_ready) check("stall_in_ready", 64'(in_ready), 64'd0);
            if (out_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_output: got fp_out %0h, expected no result", fp_out);
                end else begin
                    check("fp_out", 64'(fp_out), 64'(sb[0].word));
                    check("out_flags", 64'(out_flags), 64'(sb[0].flags));
                    if (out_ready) begin
                        sticky_model = (clear_flags ? 4'b0000 : sticky_model) | sb[0].flags;
                        void'(sb.pop_front());
                    end
                end
            end
            if (!(out_valid && out_ready) && clear_flags) sticky_model = '0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clock);
        #1;
        resetn = 1'b1;
        @(posedge clock);
        #1;

        // Plan vectors with hand-derived expectations
        send(0, 127, 27'h4000000, 0, 0, '{flags: 4'h0, word: 32'h3F80_0000});
        send(0, 127, 27'h400000C, 0, 0, '{flags: 4'h1, word: 32'h3F80_0002});
        send(0, 127, 27'h4000004, 0, 0, '{flags: 4'h1, word: 32'h3F80_0000});
        send(0, 127, 27'h7FFFFFE, 0, 0, '{flags: 4'h1, word: 32'h4000_0000});
        send(0, 255, 27'h4000000, 0, 0, '{flags: 4'h5, word: 32'h7F80_0000});
        send(1, 0,   27'h4000000, 0, 0, '{flags: 4'h3, word: 32'h8000_0000});
        send(0, 127, 27'h4000000, 1, 0, '{flags: 4'h8, word: 32'h7FC0_0000});
        drain();
        check("sticky_all", 64'(sticky_flags), 64'hF);
        @(posedge clock);
        #1;
        clear_flags = 1'b1;
        @(posedge clock);
        #1;
        clear_flags = 1'b0;
        @(negedge clock);
        check("sticky_cleared", 64'(sticky_flags), 64'h0);
        @(posedge clock);
        #1;

        // Backpressure: four back-to-back results with out_ready low for three cycles
        fork
            begin
                for (int i = 0; i < 4; i++) send_m(i[0], 100 + i, 27'h4000000 | 27'(i * 13), 0, 0);
            end
            begin
                out_ready = 1'b0;
                repeat (3) @(posedge clock);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();
        @(posedge clock);
        #1;

        // Reset with two results in flight; neither may surface afterwards
        send_m(0, 50, 27'h4123456, 0, 0);
        send_m(1, 60, 27'h4654321, 0, 0);
        resetn = 1'b0;
        @(posedge clock);
        #1;
        resetn = 1'b1;
        @(posedge clock);
        #1;

        // Randomized traffic with random backpressure and flag clears
        fork
            begin
                for (int i = 0; i < 400; i++) rand_one();
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clock);
                    #1;
                    out_ready   = ($urandom_range(0, 3) != 0);
                    clear_flags = ($urandom_range(0, 15) == 0);
                end
                out_ready   = 1'b1;
                clear_flags = 1'b0;
            end
        join
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fp_result_packer.md
Name: fp_result_packer

Overview:
- Parametrised successor to the MAC's adder result-status register stage.
- Takes an unpacked, normalised result (sign, extended exponent, significand with guard/round/sticky) and applies round-to-nearest-even, post-rounding renormalisation and special-case handling.
- Packs the result into an IEEE-754-style word of configurable width, with IEEE exception flags.
- Two-stage pipeline with valid/ready backpressure; sits between the MAC adder normaliser and the accumulator writeback.

Parameters:
- EXP_W, 8, exponent field width.
- MAN_W, 23, stored fraction width (hidden bit excluded).

Ports:
- clock  in  1  single clock.
- resetn  in  1  synchronous active-low reset.
- in_valid  in  1  input result valid.
- in_ready  out  1  block can accept input this cycle.
- in_sign  in  1  result sign.
- in_exponent  in  EXP_W+2  biased exponent, two's complement signed (allows <=0 and >=2^EXP_W-1).
- in_significand  in  MAN_W+4  bit MAN_W+3 = hidden bit, then MAN_W fraction bits, then G, R, S.
- in_is_nan  in  1  result is NaN.
- in_is_inf  in  1  result is infinity.
- clear_flags  in  1  clear sticky flags.
- out_valid  out  1  packed result valid.
- out_ready  in  1  downstream accepts.
- fp_out  out  1+EXP_W+MAN_W  {sign, exponent, fraction}.
- out_flags  out  4  per-result flags [3]=invalid [2]=overflow [1]=underflow [0]=inexact.
- sticky_flags  out  4  accumulated flags, same bit order.

Behaviour:
- Reset (resetn low at clock edge): all stage valids, out_valid, fp_out, out_flags and sticky_flags become 0. Reset mid-operation discards in-flight results with no output.
- Handshake:
  - stall = out_valid & !out_ready; in_ready = !stall (combinational).
  - Input transfers when in_valid & in_ready.
  - Output transfers when out_valid & out_ready.
  - While stalled, both stages hold; fp_out and out_flags remain stable.
- Latency: 2 cycles from input transfer to out_valid; throughput 1 result/cycle when out_ready is held high.
- Stage 1 (round):
  - lsb = sig[3], g = sig[2], rs = sig[1] | sig[0]; round_up = g & (rs | lsb).
  - m = sig[MAN_W+3:3] + round_up, computed MAN_W+2 bits wide.
  - If m[MAN_W+1] = 1 (carry out): m >>= 1 and exponent + 1.
  - inexact_raw = g | sig[1] | sig[0].
  - Register sign, exponent, m, inexact_raw, nan, inf, zero (zero = in_significand all 0).
- Stage 2 (pack/special), priority high to low:
  - nan: fp_out = {0, all-ones exp, 1, zeros}, which is the canonical qNaN; flags = invalid.
  - inf: {sign, all-ones, 0}; no flags.
  - zero: {sign, 0, 0}; no flags.
  - exp >= 2^EXP_W-1: {sign, all-ones, 0}; flags = overflow | inexact.
  - exp <= 0: flush to {sign, 0, 0}; flags = underflow | inexact. No subnormal generation.
  - otherwise: {sign, exp[EXP_W-1:0], m[MAN_W-1:0]}; flags = inexact_raw.
- Sticky flags: on an output transfer, sticky <= (clear_flags ? 0 : sticky) | out_flags. With no transfer, clear_flags sets sticky to 0. When clear and transfer happen in the same cycle, the new flags survive.
- Inputs are presumed normalised (hidden bit = 1) unless the significand is zero. A non-zero significand with hidden bit 0 is packed without correction.

Decomposition:
- Shared package fp_pkg:
  - flag index constants FLAG_INVALID=3, FLAG_OVERFLOW=2, FLAG_UNDERFLOW=1, FLAG_INEXACT=0.
  - qNaN / infinity pattern functions parametrised by EXP_W, MAN_W.
- One sub-module, fp_round_rne: combinational RNE rounding plus carry renormalisation, instantiated in stage 1.

Test Plan (EXP_W=8, MAN_W=23):
- 1.0: sign 0, exp 127, sig 0x4000000, GRS=000 -> fp_out 0x3F800000 after 2 cycles, flags 0.
- Tie, odd lsb: exp 127, frac 0x000001, GRS=100 -> 0x3F800002, inexact. Tie, even lsb: frac 0x000000, GRS=100 -> 0x3F800000, inexact.
- Carry: exp 127, hidden 1, frac 0x7FFFFF, GRS=110 -> 0x40000000, inexact.
- Specials:
  - exp 255 normal sig -> 0x7F800000, overflow|inexact.
  - sign 1, exp 0 -> 0x80000000, underflow|inexact.
  - in_is_nan -> 0x7FC00000, invalid.
  - After all three, sticky_flags = 0xF; clear_flags with no transfer -> 0x0.
- Backpressure: stream 4 values with out_ready low for 3 cycles -> in_ready drops, fp_out stable, no loss or duplication, order preserved.
- Reset mid-stream: assert resetn low with 2 results in flight -> out_valid 0 next cycle; those results never appear.
